// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display path: scan state encoding,
// blanked output patterns and the active-low hex-to-segment table.
package seven_seg_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_t;

  // Sized for the widest legal display; users slice off their digit count.
  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment cathode pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb seg = hex_seg(hex);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display scanner: one digit per divider edge,
// with an all-dark gap between digits to suppress ghosting.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int BLANK_CYCLES = 16,
  localparam int IW           = $clog2(NUM_DIGITS)
) (
  input  logic                    cin,
  input  logic                    rst,
  input  logic                    scan_tick,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [IW-1:0]           cur_digit
);

  localparam int             CW       = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IW-1:0]  DIG_LAST = IW'(NUM_DIGITS - 1);

  scan_state_t           state, nxt_state;
  logic [CW-1:0]         cnt, nxt_cnt;
  logic [IW-1:0]         nxt_digit;
  logic                  tick_q;
  logic                  step;
  logic                  blank_done;
  logic [3:0]            nib;
  logic [6:0]            nib_seg;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  assign step       = scan_tick ^ tick_q;
  assign blank_done = (BLANK_CYCLES == 0) || (cnt == CNT_LAST);

  // State, index, counter and output registers; tick_q tracks the input even
  // through reset so no phantom step appears when reset releases.
  always_ff @(posedge cin) begin
    tick_q <= scan_tick;
    if (rst) begin
      state     <= ST_BLANK;
      cnt       <= '0;
      cur_digit <= '0;
      an        <= AN_OFF[NUM_DIGITS-1:0];
      seg       <= SEG_OFF;
      dp_n      <= 1'b1;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      cur_digit <= nxt_digit;
      an        <= an_d;
      seg       <= seg_d;
      dp_n      <= dp_d;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_digit = cur_digit;
    case (state)
      ST_BLANK: begin
        if (blank_done) begin
          nxt_state = ST_SHOW;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = CW'(cnt + 1'b1);
        end
      end
      default: begin
        if (step) begin
          nxt_state = ST_BLANK;
          nxt_digit = (cur_digit == DIG_LAST) ? '0 : IW'(cur_digit + 1'b1);
        end
      end
    endcase
  end

  // Outputs are decoded from the next state/index so pins move with the state.
  assign nib = value[{nxt_digit, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex (nib),
    .seg (nib_seg)
  );

  always_comb begin
    an_d  = AN_OFF[NUM_DIGITS-1:0];
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (nxt_state == ST_SHOW) begin
      an_d[nxt_digit] = ~digit_en[nxt_digit];
      seg_d           = nib_seg;
      dp_d            = ~dp[nxt_digit];
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a per-cycle scoreboard driven by a
// lit/dark display model, plus literal checkpoints at key scan moments.
module tb_seven_seg_scanner;

  localparam int N  = 4;
  localparam int BL = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         scan_tick;
  logic [15:0]  value;
  logic [3:0]   dp;
  logic [3:0]   digit_en;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         dp_n;
  logic [1:0]   cur_digit;

  int checks = 0;
  int errors = 0;

  seven_seg_scanner #(.NUM_DIGITS(N), .BLANK_CYCLES(BL)) dut (
    .cin       (clk),
    .rst       (rst),
    .scan_tick (scan_tick),
    .value     (value),
    .dp        (dp),
    .digit_en  (digit_en),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .cur_digit (cur_digit)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Display model: either lit on digit m_digit or dark for m_dark more cycles.
  bit   m_valid = 0;
  bit   m_lit;
  int   m_dark;
  int   m_digit;
  logic m_prev;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp_n;

  always @(negedge clk) begin
    int zeros;
    zeros = 0;
    for (int i = 0; i < N; i++) if (an[i] === 1'b0) zeros++;
    if (m_valid) begin
      chk("an_onehot", (zeros <= 1), 1);
      chk("an", an, exp_an);
      chk("seg", seg, exp_seg);
      chk("dp_n", dp_n, exp_dp_n);
      chk("cur_digit", cur_digit, m_digit[1:0]);
    end
    // Inputs now are what the next rising edge samples; predict its outcome.
    if (rst) begin
      m_valid = 1;
      m_lit   = 0;
      m_dark  = (BL > 0) ? BL : 1;
      m_digit = 0;
      m_prev  = scan_tick;
    end else if (m_valid) begin
      bit toggled;
      toggled = (scan_tick != m_prev);
      m_prev  = scan_tick;
      if (!m_lit) begin
        m_dark--;
        if (m_dark == 0) m_lit = 1;
      end else if (toggled) begin
        m_lit   = 0;
        m_dark  = (BL > 0) ? BL : 1;
        m_digit = (m_digit + 1) % N;
      end
    end
    exp_an   = 4'hF;
    exp_seg  = 7'h7F;
    exp_dp_n = 1'b1;
    if (m_lit) begin
      if (digit_en[m_digit]) exp_an[m_digit] = 1'b0;
      exp_seg  = hex_tab[value[4*m_digit +: 4]];
      exp_dp_n = ~dp[m_digit];
    end
  end

  // Flip the tick now and return once the next digit has lit (#3 after edge).
  task automatic step_to_next();
    scan_tick = ~scan_tick;
    repeat (BL + 1) @(posedge clk);
    #3;
  endtask

  task automatic lit_chk(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp, input logic [1:0] e_dig);
    chk({name, "_an"}, an, e_an);
    chk({name, "_seg"}, seg, e_seg);
    chk({name, "_dp"}, dp_n, e_dp);
    chk({name, "_dig"}, cur_digit, e_dig);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; scan_tick = 0; value = 16'h1234; dp = 4'h0; digit_en = 4'hF;
    repeat (3) @(posedge clk);
    #3;
    lit_chk("reset", 4'hF, 7'h7F, 1'b1, 2'd0);
    rst = 0;

    repeat (15) @(posedge clk);
    #3;
    lit_chk("still_dark", 4'hF, 7'h7F, 1'b1, 2'd0);
    @(posedge clk); #3;
    lit_chk("first_show", 4'b1110, 7'h19, 1'b1, 2'd0);
    repeat (20) @(posedge clk);
    #3;
    lit_chk("held", 4'b1110, 7'h19, 1'b1, 2'd0);

    scan_tick = ~scan_tick;
    @(posedge clk); #3;
    lit_chk("blank_after_step", 4'hF, 7'h7F, 1'b1, 2'd1);
    repeat (BL) @(posedge clk);
    #3;
    lit_chk("digit1", 4'b1101, 7'h30, 1'b1, 2'd1);

    step_to_next(); lit_chk("digit2", 4'b1011, 7'h24, 1'b1, 2'd2);
    step_to_next(); lit_chk("digit3", 4'b0111, 7'h79, 1'b1, 2'd3);
    step_to_next(); lit_chk("wrap0", 4'b1110, 7'h19, 1'b1, 2'd0);
    step_to_next(); lit_chk("digit1b", 4'b1101, 7'h30, 1'b1, 2'd1);

    value = 16'hF0A8; dp = 4'b0100; digit_en = 4'b1011;
    @(posedge clk); #3;
    lit_chk("live_update", 4'b1101, 7'h08, 1'b1, 2'd1);
    step_to_next(); lit_chk("disabled2", 4'hF, 7'h40, 1'b0, 2'd2);
    digit_en = 4'hF;
    @(posedge clk); #3;
    lit_chk("enabled2", 4'b1011, 7'h40, 1'b0, 2'd2);
    step_to_next(); lit_chk("digitF", 4'b0111, 7'h0E, 1'b1, 2'd3);
    step_to_next(); lit_chk("digit8", 4'b1110, 7'h00, 1'b1, 2'd0);

    // Second toggle lands inside the dark gap and must be dropped.
    scan_tick = ~scan_tick;
    @(posedge clk); #3;
    scan_tick = ~scan_tick;
    repeat (BL) @(posedge clk);
    #3;
    lit_chk("double_tick", 4'b1101, 7'h08, 1'b1, 2'd1);
    repeat (5) @(posedge clk);
    #3;
    lit_chk("double_hold", 4'b1101, 7'h08, 1'b1, 2'd1);

    // Toggle sampled on the same edge that ends the gap is dropped too.
    scan_tick = ~scan_tick;
    repeat (BL) @(posedge clk);
    #3;
    scan_tick = ~scan_tick;
    @(posedge clk); #3;
    lit_chk("coincident", 4'b1011, 7'h40, 1'b0, 2'd2);
    repeat (3) @(posedge clk);
    #3;
    lit_chk("coincident_hold", 4'b1011, 7'h40, 1'b0, 2'd2);

    rst = 1;
    @(posedge clk); #3;
    rst = 0;
    lit_chk("mid_reset", 4'hF, 7'h7F, 1'b1, 2'd0);
    repeat (BL - 1) @(posedge clk);
    #3;
    lit_chk("mid_reset_dark", 4'hF, 7'h7F, 1'b1, 2'd0);
    @(posedge clk); #3;
    lit_chk("after_reset", 4'b1110, 7'h00, 1'b1, 2'd0);

    repeat (2) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
